wb_mtimer: RTL and testbench

WB_MTIMER -- requirements
Module: wb_mtimer

---
 rtl/wb_mtimer_pkg.sv | 22 ++
 rtl/common.vh | 22 ++
 rtl/wb_mtimer.sv | 156 +++++++++++++++
 tb/tb_wb_mtimer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mtimer_pkg.sv
// Helpers shared by the mtimer: byte-lane write merge for XLEN-wide registers.
`include "common.vh"

package wb_mtimer_pkg;

    localparam int XLEN       = `XLEN;
    localparam int XLEN_BYTES = `XLEN_BYTES;

    function automatic logic [XLEN-1:0] lane_merge(
        input logic [XLEN-1:0]       old_v,
        input logic [XLEN-1:0]       new_v,
        input logic [XLEN_BYTES-1:0] sel
    );
        logic [XLEN-1:0] r;
        r = old_v;
        for (int b = 0; b < XLEN_BYTES; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/common.vh
// Shared bus widths, mtimer register offsets, CTRL bit positions and reset constants.
`ifndef COMMON_VH
`define COMMON_VH

`define XLEN                 32
`define XLEN_BYTES           4
`define MM_REG_ADDR_BITS     8

`define MTIMER_OFF_MTIME_LO    3'd0
`define MTIMER_OFF_MTIME_HI    3'd1
`define MTIMER_OFF_MTIMECMP_LO 3'd2
`define MTIMER_OFF_MTIMECMP_HI 3'd3
`define MTIMER_OFF_CTRL        3'd4
`define MTIMER_OFF_PRESCALE    3'd5
`define MTIMER_NUM_REGS        6

`define MTIMER_CTRL_EN 0
`define MTIMER_CTRL_IE 1

`define MTIMER_CMP_RESET 64'hFFFF_FFFF_FFFF_FFFF

`endif

// File: rtl/wb_mtimer.sv
// Memory-mapped 64-bit machine timer with prescaler, compare interrupt and
// independent Wishbone-style read and write ports.
`include "common.vh"

module wb_mtimer
    import wb_mtimer_pkg::*;
#(
    parameter int BASE_ADDR      = 0,
    parameter int PRESCALE_RESET = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sync_reset,
    input  logic                         WB_RD_STB_I,
    input  logic [`MM_REG_ADDR_BITS-1:0] WB_RD_ADR_I,
    output logic [`XLEN-1:0]             WB_RD_DAT_O,
    output logic                         WB_RD_ACK_O,
    input  logic                         WB_WR_STB_I,
    input  logic                         WB_WR_WE_I,
    input  logic [`XLEN_BYTES-1:0]       WB_WR_SEL_I,
    input  logic [`MM_REG_ADDR_BITS-1:0] WB_WR_ADR_I,
    input  logic [`XLEN-1:0]             WB_WR_DAT_I,
    output logic                         WB_WR_ACK_O,
    output logic                         int_gen
);

    localparam logic [31:0] BASE_OFF = 32'(BASE_ADDR);

    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [17:0] presc_cnt_q, presc_cnt_d;
    logic [15:0] prescale_q, prescale_d;
    logic        en_q, en_d, ie_q, ie_d;
    logic [31:0] shadow_q, shadow_d, rd_dat_q, rd_dat_d;
    logic        rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d, int_q, int_d;

    logic [31:0] rd_off, wr_off, rd_val, wr_cur, wr_merged, ctrl_rd;
    logic        rd_hit, wr_hit, wr_go;

    // Offsets are taken in 32-bit unsigned space so addresses below BASE wrap high and miss.
    assign rd_off = 32'(WB_RD_ADR_I) - BASE_OFF;
    assign wr_off = 32'(WB_WR_ADR_I) - BASE_OFF;
    assign rd_hit = rd_off < 32'(`MTIMER_NUM_REGS);
    assign wr_hit = wr_off < 32'(`MTIMER_NUM_REGS);

    assign rd_ack_d = WB_RD_STB_I & rd_hit & ~rd_ack_q;
    assign wr_ack_d = WB_WR_STB_I & wr_hit & ~wr_ack_q;
    assign wr_go    = wr_ack_d & WB_WR_WE_I;

    always_comb begin
        ctrl_rd                 = '0;
        ctrl_rd[`MTIMER_CTRL_EN] = en_q;
        ctrl_rd[`MTIMER_CTRL_IE] = ie_q;
    end

    always_comb begin
        rd_val = '0;
        case (rd_off[2:0])
            `MTIMER_OFF_MTIME_LO:    rd_val = mtime_q[31:0];
            `MTIMER_OFF_MTIME_HI:    rd_val = shadow_q;
            `MTIMER_OFF_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
            `MTIMER_OFF_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
            `MTIMER_OFF_CTRL:        rd_val = ctrl_rd;
            `MTIMER_OFF_PRESCALE:    rd_val = {16'd0, prescale_q};
            default:                 rd_val = '0;
        endcase
        rd_dat_d = rd_ack_d ? rd_val : '0;
        shadow_d = (rd_ack_d && rd_off[2:0] == `MTIMER_OFF_MTIME_LO) ? mtime_q[63:32] : shadow_q;
    end

    always_comb begin
        wr_cur = '0;
        case (wr_off[2:0])
            `MTIMER_OFF_MTIME_LO:    wr_cur = mtime_q[31:0];
            `MTIMER_OFF_MTIME_HI:    wr_cur = mtime_q[63:32];
            `MTIMER_OFF_MTIMECMP_LO: wr_cur = mtimecmp_q[31:0];
            `MTIMER_OFF_MTIMECMP_HI: wr_cur = mtimecmp_q[63:32];
            `MTIMER_OFF_CTRL:        wr_cur = ctrl_rd;
            `MTIMER_OFF_PRESCALE:    wr_cur = {16'd0, prescale_q};
            default:                 wr_cur = '0;
        endcase
        wr_merged = lane_merge(wr_cur, WB_WR_DAT_I, WB_WR_SEL_I);
    end

    always_comb begin
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        presc_cnt_d = presc_cnt_q;
        prescale_d  = prescale_q;
        en_d        = en_q;
        ie_d        = ie_q;
        if (en_q) begin
            if (presc_cnt_q == {2'b00, prescale_q}) begin
                presc_cnt_d = '0;
                mtime_d     = mtime_q + 64'd1;
            end else begin
                presc_cnt_d = presc_cnt_q + 18'd1;
            end
        end
        // A bus write to MTIME overrides the increment and restarts the prescale phase.
        if (wr_go) begin
            case (wr_off[2:0])
                `MTIMER_OFF_MTIME_LO: begin
                    mtime_d     = {mtime_q[63:32], wr_merged};
                    presc_cnt_d = '0;
                end
                `MTIMER_OFF_MTIME_HI: begin
                    mtime_d     = {wr_merged, mtime_q[31:0]};
                    presc_cnt_d = '0;
                end
                `MTIMER_OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = wr_merged;
                `MTIMER_OFF_MTIMECMP_HI: mtimecmp_d[63:32] = wr_merged;
                `MTIMER_OFF_CTRL: begin
                    en_d = wr_merged[`MTIMER_CTRL_EN];
                    ie_d = wr_merged[`MTIMER_CTRL_IE];
                end
                `MTIMER_OFF_PRESCALE: prescale_d = wr_merged[15:0];
                default: ;
            endcase
        end
        int_d = ie_q & (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || sync_reset) begin
            mtime_q     <= '0;
            mtimecmp_q  <= `MTIMER_CMP_RESET;
            presc_cnt_q <= '0;
            prescale_q  <= 16'(PRESCALE_RESET);
            en_q        <= 1'b0;
            ie_q        <= 1'b0;
            shadow_q    <= '0;
            rd_dat_q    <= '0;
            rd_ack_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            presc_cnt_q <= presc_cnt_d;
            prescale_q  <= prescale_d;
            en_q        <= en_d;
            ie_q        <= ie_d;
            shadow_q    <= shadow_d;
            rd_dat_q    <= rd_dat_d;
            rd_ack_q    <= rd_ack_d;
            wr_ack_q    <= wr_ack_d;
            int_q       <= int_d;
        end
    end

    assign WB_RD_DAT_O = rd_dat_q;
    assign WB_RD_ACK_O = rd_ack_q;
    assign WB_WR_ACK_O = wr_ack_q;
    assign int_gen     = int_q;

endmodule

// File: tb/tb_wb_mtimer.sv
// Randomised and directed bench for wb_mtimer against a per-cycle behavioural model.
module tb_wb_mtimer;

    localparam int BASE      = 16;
    localparam int PRESC_RST = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_reset = 1'b0;
    logic        rd_stb = 1'b0;
    logic [7:0]  rd_adr = '0;
    logic [31:0] rd_dat;
    logic        rd_ack;
    logic        wr_stb = 1'b0;
    logic        wr_we = 1'b0;
    logic [3:0]  wr_sel = '0;
    logic [7:0]  wr_adr = '0;
    logic [31:0] wr_dat = '0;
    logic        wr_ack;
    logic        int_gen;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_mtimer #(.BASE_ADDR(BASE), .PRESCALE_RESET(PRESC_RST)) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .WB_RD_STB_I(rd_stb), .WB_RD_ADR_I(rd_adr), .WB_RD_DAT_O(rd_dat), .WB_RD_ACK_O(rd_ack),
        .WB_WR_STB_I(wr_stb), .WB_WR_WE_I(wr_we), .WB_WR_SEL_I(wr_sel), .WB_WR_ADR_I(wr_adr),
        .WB_WR_DAT_I(wr_dat), .WB_WR_ACK_O(wr_ack), .int_gen(int_gen)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: architectural registers plus the expected bus outputs.
    logic [63:0] m_time, m_cmp;
    int unsigned m_cnt;
    logic [15:0] m_presc;
    bit          m_en, m_ie, m_int, m_rd_ack, m_wr_ack;
    logic [31:0] m_shadow, m_rd_dat;

    function automatic logic [31:0] mrg(input logic [31:0] old_v, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_time = '0; m_cmp = '1; m_cnt = 0; m_presc = 16'(PRESC_RST);
        m_en = 0; m_ie = 0; m_int = 0; m_rd_ack = 0; m_wr_ack = 0;
        m_shadow = '0; m_rd_dat = '0;
    endtask

    task automatic model_step();
        int ro, wo;
        bit rf, wf;
        logic [63:0] t0;
        logic [31:0] rv, cur;
        if (sync_reset) begin
            model_reset();
            return;
        end
        ro = int'(rd_adr) - BASE;
        wo = int'(wr_adr) - BASE;
        rf = rd_stb && ro >= 0 && ro < 6 && !m_rd_ack;
        wf = wr_stb && wo >= 0 && wo < 6 && !m_wr_ack;
        t0 = m_time;
        rv = '0;
        if (rf) begin
            case (ro)
                0: rv = t0[31:0];
                1: rv = m_shadow;
                2: rv = m_cmp[31:0];
                3: rv = m_cmp[63:32];
                4: rv = {30'd0, m_ie, m_en};
                default: rv = {16'd0, m_presc};
            endcase
            if (ro == 0) m_shadow = t0[63:32];
        end
        m_rd_dat = rv;
        m_rd_ack = rf;
        m_wr_ack = wf;
        m_int = m_ie && (t0 >= m_cmp);
        if (m_en) begin
            if (m_cnt == 32'(m_presc)) begin
                m_cnt = 0;
                m_time = m_time + 64'd1;
            end else begin
                m_cnt = (m_cnt + 1) % 262144;
            end
        end
        if (wf && wr_we) begin
            case (wo)
                0: begin m_time = {t0[63:32], mrg(t0[31:0], wr_dat, wr_sel)}; m_cnt = 0; end
                1: begin m_time = {mrg(t0[63:32], wr_dat, wr_sel), t0[31:0]}; m_cnt = 0; end
                2: m_cmp[31:0] = mrg(m_cmp[31:0], wr_dat, wr_sel);
                3: m_cmp[63:32] = mrg(m_cmp[63:32], wr_dat, wr_sel);
                4: begin cur = mrg({30'd0, m_ie, m_en}, wr_dat, wr_sel); m_en = cur[0]; m_ie = cur[1]; end
                default: begin cur = mrg({16'd0, m_presc}, wr_dat, wr_sel); m_presc = cur[15:0]; end
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("rd_ack", rd_ack, m_rd_ack);
        check("wr_ack", wr_ack, m_wr_ack);
        check("rd_dat", rd_dat, m_rd_dat);
        check("int_gen", int_gen, m_int);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] sel = 4'hF);
        wr_stb = 1; wr_we = 1; wr_adr = 8'(BASE + off); wr_dat = d; wr_sel = sel;
        cycle();
        wr_stb = 0; wr_we = 0;
        cycle();
    endtask

    task automatic rd(input int off, output logic [31:0] d);
        rd_stb = 1; rd_adr = 8'(BASE + off);
        cycle();
        d = rd_dat;
        rd_stb = 0;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d2;
        bit a1, a2, a3;
        int k, off;

        model_reset();
        repeat (2) @(negedge clk);
        check("rst_rd_ack", rd_ack, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_rd_dat", rd_dat, 0);
        check("rst_int", int_gen, 0);
        reset_n = 1;

        rd(5, d); check("rst_presc", d, PRESC_RST);
        rd(2, d); check("rst_cmp_lo", d, 32'hFFFF_FFFF);
        rd(3, d); check("rst_cmp_hi", d, 32'hFFFF_FFFF);
        rd(4, d); check("rst_ctrl", d, 0);
        rd(0, d); check("rst_mtime_lo", d, 0);

        // PRESCALE=0, EN=1: one increment per cycle
        wr(5, 0);
        wr(4, 1);
        rd(0, d); idle(4); rd(0, d2);
        check("rate_presc0", d2 - d, 6);

        rd_stb = 1; rd_adr = 8'(BASE);
        cycle(); a1 = rd_ack;
        cycle(); a2 = rd_ack;
        cycle(); a3 = rd_ack;
        rd_stb = 0;
        cycle();
        check("held_stb_ack", {a1, a2, a3}, 3'b101);

        // PRESCALE=3: one increment every 4 cycles, then freeze
        wr(5, 3);
        rd(0, d); idle(6); rd(0, d2);
        check("rate_presc3", d2 - d, 2);
        wr(4, 0);
        rd(0, d); idle(10); rd(0, d2);
        check("freeze", d2, d);
        wr(4, 1); idle(9);

        // 64-bit wrap
        wr(4, 0); wr(5, 0);
        wr(1, 32'hFFFF_FFFF); wr(0, 32'hFFFF_FFFE);
        wr(4, 1);
        rd(0, d); check("max_lo", d, 32'hFFFF_FFFF);
        rd(1, d); check("max_hi", d, 32'hFFFF_FFFF);
        rd(0, d); check("wrap_lo", d, 3);
        rd(1, d); check("wrap_hi", d, 0);

        // compare interrupt
        wr(4, 0); wr(1, 0); wr(0, 90); wr(3, 0); wr(2, 100);
        wr(4, 3);
        k = 1;
        while (int_gen !== 1'b1 && k < 50) begin
            cycle();
            k++;
        end
        check("int_rise_cycle", k, 11);
        wr(2, 32'hFFFF_FFFF);
        wr(3, 32'hFFFF_FFFF);
        check("int_drop", int_gen, 0);

        // byte lanes, WE=0, unmapped offsets
        wr(4, 0); wr(5, 0);
        wr(5, 32'h0000_AB00, 4'b0010);
        rd(5, d); check("presc_lane1", d, 32'h0000_AB00);
        wr_stb = 1; wr_we = 0; wr_adr = 8'(BASE + 5); wr_dat = 5; wr_sel = 4'hF;
        cycle(); check("we0_ack", wr_ack, 1);
        wr_stb = 0; cycle();
        rd(5, d); check("we0_noeffect", d, 32'h0000_AB00);
        rd(7, d); check("unmapped7_dat", d, 0);
        rd_stb = 1; rd_adr = 8'(BASE - 1);
        cycle(); check("below_base_ack", rd_ack, 0);
        rd_stb = 0;
        wr_stb = 1; wr_we = 1; wr_adr = 8'(BASE + 6);
        cycle(); check("unmapped_wr_ack", wr_ack, 0);
        wr_stb = 0; wr_we = 0; cycle();

        // synchronous reset
        wr(5, 9); wr(4, 1);
        sync_reset = 1; cycle(); sync_reset = 0;
        rd(5, d); check("srst_presc", d, PRESC_RST);

        // asynchronous reset in the middle of a write
        wr(2, 0); wr(3, 0); wr(4, 3);
        check("int_before_arst", int_gen, 1);
        wr_stb = 1; wr_we = 1; wr_adr = 8'(BASE + 5); wr_dat = 7; wr_sel = 4'hF;
        rd_stb = 1; rd_adr = 8'(BASE);
        #2 reset_n = 0;
        model_reset();
        #1;
        check("arst_wr_ack", wr_ack, 0);
        check("arst_rd_ack", rd_ack, 0);
        check("arst_rd_dat", rd_dat, 0);
        check("arst_int", int_gen, 0);
        @(posedge clk);
        @(negedge clk);
        check("arst_hold_wr_ack", wr_ack, 0);
        wr_stb = 0; wr_we = 0; rd_stb = 0;
        reset_n = 1;
        rd(5, d); check("arst_presc", d, PRESC_RST);
        rd(4, d); check("arst_ctrl", d, 0);
        rd(3, d); check("arst_cmp_hi", d, 32'hFFFF_FFFF);
        rd(0, d); check("arst_mtime_lo", d, 0);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rd_stb = ($urandom_range(0, 2) == 0);
            rd_adr = 8'($urandom_range(BASE + 8, BASE - 2));
            wr_stb = ($urandom_range(0, 3) == 0);
            wr_we  = ($urandom_range(0, 4) != 0);
            wr_adr = 8'($urandom_range(BASE + 8, BASE - 2));
            wr_sel = 4'($urandom);
            off = int'(wr_adr) - BASE;
            case (off)
                2: wr_dat = m_time[31:0] + 32'($urandom_range(0, 40));
                3: wr_dat = m_time[63:32];
                5: wr_dat = 32'($urandom_range(0, 3));
                0, 1: wr_dat = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                default: wr_dat = 32'($urandom);
            endcase
            sync_reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rd_stb = 0; wr_stb = 0; wr_we = 0; sync_reset = 0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
